// File: rtl/matrix_coef_ctrl.sv
// rtl/matrix_coef_ctrl.sv - 3x3 colour matrix coefficient bank with frame-synchronous commit
// Optional coefficient readback port enabled by COEF_READBACK_EN.
module matrix_coef_ctrl #(
  parameter int MSIZE = 8,
  parameter int NSIZE = 1,
  parameter int LAT   = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [MSIZE-1:0] wr_data,
  input  logic             commit,
  input  logic             iVS,
  input  logic             iHS,
  input  logic             iDE,
`ifdef COEF_READBACK_EN
  input  logic [3:0]       rd_addr,
  output logic [MSIZE-1:0] rd_data,
`endif
  output logic             oVS,
  output logic             oHS,
  output logic             oDE,
  output logic [MSIZE-1:0] M00,
  output logic [MSIZE-1:0] M01,
  output logic [MSIZE-1:0] M02,
  output logic [MSIZE-1:0] M10,
  output logic [MSIZE-1:0] M11,
  output logic [MSIZE-1:0] M12,
  output logic [MSIZE-1:0] M20,
  output logic [MSIZE-1:0] M21,
  output logic [MSIZE-1:0] M22,
  output logic             busy,
  output logic             apply_done,
  output logic             err_addr
);

  localparam logic [MSIZE-1:0] UNITY = {{(MSIZE-1){1'b0}}, 1'b1} << (MSIZE - NSIZE - 2);

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

  state_t           state_q, state_d;
  logic             vs_prev_q;
  logic             copy_en;
  logic             apply_done_q;
  logic             err_addr_q;
  logic [MSIZE-1:0] shadow_q [9];
  logic [MSIZE-1:0] active_q [9];
  logic [2:0]       dly_q [LAT];

  always_ff @(posedge clock) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The commit cycle itself is always IDLE, so an iVS edge coinciding with it never counts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit) state_d = PENDING;
      PENDING: if (iVS && !vs_prev_q) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    copy_en = (state_q == APPLY);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      vs_prev_q    <= 1'b0;
      apply_done_q <= 1'b0;
      err_addr_q   <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        shadow_q[i] <= (i % 4 == 0) ? UNITY : '0;
        active_q[i] <= (i % 4 == 0) ? UNITY : '0;
      end
    end else begin
      vs_prev_q    <= iVS;
      apply_done_q <= copy_en;
      err_addr_q   <= wr_en && (wr_addr > 4'd8);
      // Copy reads the pre-edge shadow, so a write during APPLY waits for the next commit.
      if (copy_en) active_q <= shadow_q;
      if (wr_en && (wr_addr <= 4'd8)) shadow_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) dly_q[i] <= 3'b000;
    end else begin
      dly_q[0] <= {iVS, iHS, iDE};
      for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

`ifdef COEF_READBACK_EN
  logic [MSIZE-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (!rst_n)                 rd_data_q <= '0;
    else if (rd_addr <= 4'd8)   rd_data_q <= active_q[rd_addr];
    else                        rd_data_q <= '0;
  end

  assign rd_data = rd_data_q;
`endif

  assign {oVS, oHS, oDE} = dly_q[LAT-1];
  assign apply_done      = apply_done_q;
  assign err_addr        = err_addr_q;
  assign M00 = active_q[0];
  assign M01 = active_q[1];
  assign M02 = active_q[2];
  assign M10 = active_q[3];
  assign M11 = active_q[4];
  assign M12 = active_q[5];
  assign M20 = active_q[6];
  assign M21 = active_q[7];
  assign M22 = active_q[8];

endmodule

// File: tb/tb_matrix_coef_ctrl.sv
// tb/tb_matrix_coef_ctrl.sv - directed self-checking bench for matrix_coef_ctrl
module tb_matrix_coef_ctrl;

  logic       clock = 1'b0;
  logic       rst_n, wr_en, commit, iVS, iHS, iDE;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       oVS, oHS, oDE, busy, apply_done, err_addr;
  logic [7:0] M00, M01, M02, M10, M11, M12, M20, M21, M22;
`ifdef COEF_READBACK_EN
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;
`endif

  int checks   = 0;
  int failures = 0;
  int pulses;

  always #5 clock = ~clock;

  matrix_coef_ctrl dut (
    .clock(clock), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .iVS(iVS), .iHS(iHS), .iDE(iDE),
`ifdef COEF_READBACK_EN
    .rd_addr(rd_addr), .rd_data(rd_data),
`endif
    .oVS(oVS), .oHS(oHS), .oDE(oDE),
    .M00(M00), .M01(M01), .M02(M02), .M10(M10), .M11(M11), .M12(M12),
    .M20(M20), .M21(M21), .M22(M22),
    .busy(busy), .apply_done(apply_done), .err_addr(err_addr)
  );

  typedef struct {
    logic de, hs, vs;
    logic exp_de, exp_hs, exp_vs;
  } sync_vec_t;

  typedef struct {
    logic       en;
    logic [3:0] addr;
    logic [7:0] data;
    logic       exp_err;
  } wr_vec_t;

  sync_vec_t sync_tbl [12];
  wr_vec_t   wr_tbl [4];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  initial begin
    sync_tbl[0]  = '{1,0,0, 0,0,0};
    sync_tbl[1]  = '{0,1,0, 0,0,0};
    sync_tbl[2]  = '{1,1,0, 0,0,0};
    sync_tbl[3]  = '{1,0,1, 0,0,0};
    sync_tbl[4]  = '{0,1,1, 1,0,0};
    sync_tbl[5]  = '{1,0,0, 0,1,0};
    sync_tbl[6]  = '{0,0,0, 1,1,0};
    sync_tbl[7]  = '{0,1,0, 1,0,1};
    sync_tbl[8]  = '{0,0,0, 0,1,1};
    sync_tbl[9]  = '{0,0,0, 1,0,0};
    sync_tbl[10] = '{0,0,0, 0,0,0};
    sync_tbl[11] = '{0,0,0, 0,1,0};

    wr_tbl[0] = '{1'b1, 4'd1,  8'h85, 1'b0};
    wr_tbl[1] = '{1'b1, 4'd9,  8'h7F, 1'b1};
    wr_tbl[2] = '{1'b1, 4'd15, 8'h01, 1'b1};
    wr_tbl[3] = '{1'b0, 4'd9,  8'h55, 1'b0};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;
    commit = 1'b0; iVS = 1'b0; iHS = 1'b0; iDE = 1'b0;
    tick(); tick();
    chk("reset_busy", busy, 0);
    chk("reset_apply_done", apply_done, 0);
    chk("reset_err_addr", err_addr, 0);
    rst_n = 1'b1;
    tick();
    chk("identity", {M00, M01, M02, M10, M11, M12, M20, M21, M22},
        {8'd32, 8'd0, 8'd0, 8'd0, 8'd32, 8'd0, 8'd0, 8'd0, 8'd32});
    chk("reset_oDE", {oVS, oHS, oDE}, 3'b000);
    chk("reset_busy_after", busy, 0);

    for (int i = 0; i < 12; i++) begin
      iDE = sync_tbl[i].de; iHS = sync_tbl[i].hs; iVS = sync_tbl[i].vs;
      #1;
      chk($sformatf("delay_de_%0d", i), oDE, sync_tbl[i].exp_de);
      chk($sformatf("delay_hs_%0d", i), oHS, sync_tbl[i].exp_hs);
      chk($sformatf("delay_vs_%0d", i), oVS, sync_tbl[i].exp_vs);
      tick();
    end
    chk("idle_after_sync", busy, 0);

    for (int i = 0; i < 4; i++) begin
      wr_en = wr_tbl[i].en; wr_addr = wr_tbl[i].addr; wr_data = wr_tbl[i].data;
      tick();
      wr_en = 1'b0;
      chk($sformatf("err_pulse_%0d", i), err_addr, wr_tbl[i].exp_err);
      chk($sformatf("active_held_%0d", i), {M00, M01, M11, M22}, {8'd32, 8'd0, 8'd32, 8'd32});
      tick();
      chk($sformatf("err_clear_%0d", i), err_addr, 0);
    end

    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("pending_busy", busy, 1);
    for (int i = 0; i < 20; i++) tick();
    chk("pending_hold_busy", busy, 1);
    chk("pending_hold_M01", M01, 8'h00);
    iVS = 1'b1;
    tick();
    chk("apply_busy", busy, 1);
    chk("apply_M01_old", M01, 8'h00);
    chk("apply_done_early", apply_done, 0);
    tick();
    iVS = 1'b0;
    chk("commit_M01", M01, 8'h85);
    chk("commit_apply_done", apply_done, 1);
    chk("commit_busy", busy, 0);
    chk("commit_others", {M00, M02, M11, M22}, {8'd32, 8'd0, 8'd32, 8'd32});
    tick();
    chk("apply_done_single", apply_done, 0);

    commit = 1'b1;
    tick();
    tick();
    commit = 1'b0;
    iVS = 1'b1; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h10;
    tick();
    wr_en = 1'b0; iVS = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) chk("trigger_write_M11", M11, 8'h10);
      if (i == 3) iVS = 1'b1;
      if (i == 4) iVS = 1'b0;
      pulses += int'(apply_done);
    end
    chk("double_commit_pulses", pulses, 1);
    chk("double_commit_busy", busy, 0);

    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h33;
    tick();
    wr_en = 1'b0; commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    iVS = 1'b1;
    tick();
    iVS = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      pulses += int'(apply_done);
      tick();
    end
    chk("reset_pending_pulses", pulses, 0);
    chk("reset_pending_busy", busy, 0);
    chk("reset_pending_coefs", {M01, M02, M11}, {8'd0, 8'd0, 8'd32});

    commit = 1'b1;
    tick();
    commit = 1'b0; iVS = 1'b1;
    tick();
    iVS = 1'b0;
    tick();
    chk("shadow_reset_apply", apply_done, 1);
    chk("shadow_reset_coefs", {M01, M02, M11}, {8'd0, 8'd0, 8'd32});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_coef_ctrl.md
MATRIX_COEF_CTRL -- requirements
Module: matrix_coef_ctrl

Interface
REQ-001 SHALL have parameter MSIZE, default 8: coefficient width (sign-magnitude; MSB is the sign).
REQ-002 SHALL have parameter NSIZE, default 1: integer bits of the downstream multiplier output; sets the unity value UNITY = 1<<(MSIZE-NSIZE-2) (32 at the defaults).
REQ-003 SHALL have parameter LAT, default 4: downstream multiplier latency in clocks.
REQ-004 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-006 SHALL have port wr_en, input, 1: shadow coefficient write strobe.
REQ-007 SHALL have port wr_addr, input, 4: coefficient index 0..8 = M00,M01,M02,M10,M11,M12,M20,M21,M22.
REQ-008 SHALL have port wr_data, input, MSIZE: coefficient value.
REQ-009 SHALL have port commit, input, 1: request to move the shadow bank to the active bank.
REQ-010 SHALL have ports iVS, iHS, iDE, input, 1 each: video sync and data enable aligned with the pixel fed to the multiplier.
REQ-011 SHALL have ports oVS, oHS, oDE, output, 1 each: sync and enable delayed to align with the multiplier output.
REQ-012 SHALL have ports M00..M22, output, MSIZE each: active coefficients, driven from registers.
REQ-013 SHALL have port busy, output, 1: high while a commit is pending or being applied.
REQ-014 SHALL have port apply_done, output, 1: one-cycle pulse when the active bank updates.
REQ-015 SHALL have port err_addr, output, 1: one-cycle pulse on a write with wr_addr>8.

Function
REQ-016 SHALL update the shadow entry on the next edge when wr_en=1 and wr_addr<=8; the active outputs SHALL NOT change.
REQ-017 SHALL ignore a write with wr_addr>8 and SHALL pulse err_addr on the next cycle.
REQ-018 SHALL implement FSM states IDLE, PENDING and APPLY; busy=1 in PENDING and in APPLY.
REQ-019 IDLE->PENDING SHALL occur on commit=1; commit in PENDING or APPLY SHALL be ignored.
REQ-020 PENDING->APPLY SHALL occur on the iVS rising edge (iVS=1 while the registered previous iVS=0); an edge in the same cycle as the commit SHALL NOT count.
REQ-021 In APPLY, SHALL copy all 9 shadow registers to the active registers in one edge, pulse apply_done, and return to IDLE.
REQ-022 A write coinciding with the PENDING->APPLY cycle SHALL land in shadow, and SHALL be included in the copy; writes after APPLY SHALL be held for the next commit.
REQ-023 SHALL delay oVS/oHS/oDE by exactly LAT cycles through a shift register.
REQ-024 Coefficients SHALL never change mid-frame; the update SHALL be visible at the multiplier's first input cycle of the new frame plus one clock.

Reset
REQ-025 While rst_n=0 at an edge: state=IDLE; busy, apply_done, err_addr=0; the delay line and oVS/oHS/oDE=0.
REQ-026 Reset SHALL load both banks with identity: M00=M11=M22=UNITY, others 0.
REQ-027 Reset during PENDING SHALL discard the pending commit.

Configuration
REQ-028 With macro COEF_READBACK_EN defined, SHALL add rd_addr (input, 4) and rd_data (output, MSIZE); rd_data SHALL be the registered active coefficient 1 cycle after rd_addr; it SHALL be 0 for addr>8 and 0 at reset.
REQ-029 Without COEF_READBACK_EN, these ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Release reset -> M00=M11=M22=32, other coefficients 0, busy=0, oDE=0.
REQ-031 Write addr1=0x85, then commit, with no iVS -> M01 stays 0 and busy=1 indefinitely; iVS 0->1 -> the next cycle shows APPLY, the following edge gives M01=0x85, apply_done pulses once, busy=0.
REQ-032 Write addr 9 data 0x7F -> err_addr pulses for 1 cycle; shadow and active are unchanged.
REQ-033 Drive iDE with pattern 1,0,1,1 -> oDE shows the identical pattern exactly 4 cycles later.
REQ-034 Commit, then a second commit, then a write of addr4=0x10 in the APPLY-trigger cycle -> a single apply_done; M11=0x10.
REQ-035 Reset asserted while PENDING, then an iVS edge -> no apply_done; coefficients are at identity.
